lbdr_dr_route_unit: RTL and testbench
=====================================

// Module: lbdr_dr_route_unit
// PURPOSE
//  Per-input-port LBDR routing unit for a 2-D mesh NoC, parametrised in mesh coordinate width.
//  Latches the routing, connectivity and deroute configuration at reset.
//  Routes each HEADER flit to one output port (minimal first, deroute fallback).
//  Holds that port for the rest of the packet, through TAIL, with a valid/ready flit handshake.
//  Sits between an input FIFO and the crossbar allocator. No forks: exactly one port per packet.
// PARAMETERS
//  XW       2       bits of X coordinate
//  YW       2       bits of Y coordinate
//  HDR_ID   3'b001  flit_id code of a HEADER flit
//  TAIL_ID  3'b100  flit_id code of a TAIL flit; any other code is a body flit
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous, active-high reset; samples all cfg_* inputs
//  cfg_rxy       in   8        {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, bit0 = Rne
//  cfg_cx        in   4        {Cs,Cw,Ce,Cn}; 1 = output port connected
//  cfg_dr        in   8        deroute code per straight dir: [1:0]=N [3:2]=E [5:4]=W [7:6]=S;
//                              code 0=N 1=E 2=W 3=S
//  cfg_cur_addr  in   XW+YW    node address {y,x}
//  flit_valid    in   1        FIFO head flit valid (i.e. !empty)
//  flit_id       in   3        head flit type
//  dst_addr      in   XW+YW    destination {y,x}; meaningful on HEADER only
//  out_ready     in   1        allocator accepts a flit on the held port
//  flit_ready    out  1        flit consumed this cycle when flit_valid & flit_ready
//  port_req      out  5        one-hot {L,S,W,E,N}; held for the whole packet
//  route_valid   out  1        port_req is valid
//  derouted      out  1        current packet took a deroute port
//  route_err     out  1        one-cycle pulse on routing or protocol error
// BEHAVIOUR
//  Reset
//   - Configuration registers load from the cfg_* inputs; they are not sampled at any other time.
//   - FSM goes to IDLE. All outputs 0.
//   - Reset mid-packet abandons the packet with no error pulse.
//  FSM states and transitions
//   - IDLE: flit_ready=1.
//     - Accepted HEADER: compute route; on success go to HOLD, on failure go to DROP.
//     - Accepted non-HEADER: discard it and pulse route_err.
//   - HOLD: route_valid=1, flit_ready=out_ready.
//     - Accepted TAIL: return to IDLE; port_req, route_valid and derouted clear the next cycle.
//     - Accepted HEADER: pulse route_err, then re-route it as a new packet.
//   - DROP: flit_ready=1; consume flits until TAIL, then return to IDLE.
//  Timing
//   - Route latency is 1 cycle: port_req is registered in the edge that accepts the HEADER.
//   - A single-flit packet (HDR_ID == TAIL_ID is illegal) needs HEADER followed by TAIL.
//  Direction compare (unsigned)
//   - N1 = ydst<ycur, S1 = ycur<ydst, E1 = xcur<xdst, W1 = xdst<xcur.
//  Minimal request
//   - N = (N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw) & Cn.
//   - E, W and S follow the same form, using Ren/Res, Rwn/Rws and Rse/Rsw respectively.
//   - L = ~N1&~S1&~E1&~W1.
//  Port selection
//   - Several minimal ports set: pick by priority L>N>E>W>S.
//   - No minimal port and the destination is straight (one of N1/E1/W1/S1 only):
//     - use that direction's cfg_dr code; derouted=1.
//     - only if the coded port has Cx=1 and the code differs from the blocked direction.
//   - Diagonal destination with no minimal port: failure.
//   - Failure of either kind: route_err pulse, packet dropped.
//  Simultaneity
//   - route_err asserts in the same cycle as the new port_req when a HEADER interrupts HOLD.
//  Widths
//   - Compares are XW/YW wide with no wrap-around (mesh, not torus).
// TESTING
//  Config for all tests: rxy=8'h3C, cx=4'hF, dr=8'h00, cur=4'b0101 (x=1,y=1).
//  1. rst, then HEADER dst=4'b0111, PAYLOAD, TAIL, out_ready=1
//     -> port_req=5'b00010 (E) from cycle+1 through TAIL; 0 one cycle after TAIL.
//  2. HEADER dst=4'b0101 -> port_req=5'b10000 (L), derouted=0.
//  3. cx=4'b1110 (Cn=0), dr[1:0]=2'd1, HEADER dst=4'b0001 (north)
//     -> port_req=E, derouted=1; with dr[1:0]=2'd0 instead -> route_err, DROP until TAIL.
//  4. HOLD with out_ready=0 for 3 cycles -> flit_ready=0, FIFO head not consumed, port_req stable.
//  5. HEADER mid-packet in HOLD -> route_err 1-cycle pulse, port_req updated to the new route;
//     PAYLOAD in IDLE -> dropped, route_err.
//  6. rst asserted in HOLD -> next cycle all outputs 0, state IDLE, new cfg values in effect.

Source files
------------

// File: rtl/lbdr_dr_route_unit.sv
// LBDR routing unit for one input port of a 2-D mesh NoC.
// Configuration is captured during reset. Each HEADER flit is routed to a
// single output port: a minimal port if one exists, otherwise the deroute
// port when the destination is straight. The port is held through the TAIL.
module lbdr_dr_route_unit #(
  parameter int          XW      = 2,
  parameter int          YW      = 2,
  parameter logic [2:0]  HDR_ID  = 3'b001,
  parameter logic [2:0]  TAIL_ID = 3'b100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cfg_rxy,
  input  logic [3:0]         cfg_cx,
  input  logic [7:0]         cfg_dr,
  input  logic [XW+YW-1:0]   cfg_cur_addr,
  input  logic               flit_valid,
  input  logic [2:0]         flit_id,
  input  logic [XW+YW-1:0]   dst_addr,
  input  logic               out_ready,
  output logic               flit_ready,
  output logic [4:0]         port_req,
  output logic               route_valid,
  output logic               derouted,
  output logic               route_err
);
  localparam int AW = XW + YW;

  typedef enum logic [1:0] {IDLE, HOLD, DROP} state_t;
  state_t state;

  logic [7:0]    rxy_q;
  logic [3:0]    cx_q;
  logic [7:0]    dr_q;
  logic [AW-1:0] cur_q;

  // Configuration is only sampled while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxy_q <= cfg_rxy;
      cx_q  <= cfg_cx;
      dr_q  <= cfg_dr;
      cur_q <= cfg_cur_addr;
    end
  end

  logic [XW-1:0] xcur, xdst;
  logic [YW-1:0] ycur, ydst;
  assign xcur = cur_q[XW-1:0];
  assign ycur = cur_q[AW-1:XW];
  assign xdst = dst_addr[XW-1:0];
  assign ydst = dst_addr[AW-1:XW];

  // Mesh, not torus: plain unsigned compares, no wrap.
  logic n1, s1, e1, w1;
  assign n1 = ydst < ycur;
  assign s1 = ycur < ydst;
  assign e1 = xcur < xdst;
  assign w1 = xdst < xcur;

  logic min_n, min_e, min_w, min_s, min_l;
  assign min_n = (n1 & ~e1 & ~w1 | n1 & e1 & rxy_q[0] | n1 & w1 & rxy_q[1]) & cx_q[0];
  assign min_e = (e1 & ~n1 & ~s1 | e1 & n1 & rxy_q[2] | e1 & s1 & rxy_q[3]) & cx_q[1];
  assign min_w = (w1 & ~n1 & ~s1 | w1 & n1 & rxy_q[4] | w1 & s1 & rxy_q[5]) & cx_q[2];
  assign min_s = (s1 & ~e1 & ~w1 | s1 & e1 & rxy_q[6] | s1 & w1 & rxy_q[7]) & cx_q[3];
  assign min_l = ~n1 & ~s1 & ~e1 & ~w1;

  // Straight destination: its direction index (0=N 1=E 2=W 3=S) selects
  // the deroute code; the code uses the same encoding as port_req bits.
  logic       straight;
  logic [1:0] blk_dir, dr_code;
  assign straight = $onehot({s1, w1, e1, n1});
  assign blk_dir  = n1 ? 2'd0 : e1 ? 2'd1 : w1 ? 2'd2 : 2'd3;
  assign dr_code  = dr_q[{blk_dir, 1'b0} +: 2];

  logic [4:0] rt_port;
  logic       rt_der, rt_ok;

  // Port selection: L>N>E>W>S among minimal ports, then deroute, else fail.
  always_comb begin
    rt_port = '0;
    rt_der  = 1'b0;
    rt_ok   = 1'b1;
    if (min_l)      rt_port = 5'b10000;
    else if (min_n) rt_port = 5'b00001;
    else if (min_e) rt_port = 5'b00010;
    else if (min_w) rt_port = 5'b00100;
    else if (min_s) rt_port = 5'b01000;
    else if (straight && cx_q[dr_code] && dr_code != blk_dir) begin
      rt_port = 5'b00001 << dr_code;
      rt_der  = 1'b1;
    end else
      rt_ok = 1'b0;
  end

  logic is_hdr, is_tail, accept;
  assign is_hdr  = flit_id == HDR_ID;
  assign is_tail = flit_id == TAIL_ID;
  assign accept  = flit_valid & flit_ready;

  // Only the held packet is back-pressured by the allocator.
  always_comb begin
    flit_ready = 1'b0;
    if (!rst) flit_ready = (state == HOLD) ? out_ready : 1'b1;
  end

  // Packet FSM with registered route outputs; route_err is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      port_req    <= '0;
      route_valid <= 1'b0;
      derouted    <= 1'b0;
      route_err   <= 1'b0;
    end else begin
      route_err <= 1'b0;
      if (accept) begin
        if (state != DROP && is_hdr) begin
          // A HEADER while holding is a protocol error but is still routed.
          route_err <= ~rt_ok | (state == HOLD);
          if (rt_ok) begin
            state       <= HOLD;
            port_req    <= rt_port;
            route_valid <= 1'b1;
            derouted    <= rt_der;
          end else begin
            state       <= DROP;
            port_req    <= '0;
            route_valid <= 1'b0;
            derouted    <= 1'b0;
          end
        end else if (state == IDLE) begin
          route_err <= 1'b1;
        end else if (is_tail) begin
          state       <= IDLE;
          port_req    <= '0;
          route_valid <= 1'b0;
          derouted    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_lbdr_dr_route_unit.sv
// Scoreboard bench for lbdr_dr_route_unit: a reference model predicts the
// registered outputs for every driven cycle and queues them for comparison.
module tb_lbdr_dr_route_unit;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] PAY = 3'b010;
  localparam logic [2:0] TAL = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cfg_rxy = 8'h3C;
  logic [3:0] cfg_cx = 4'hF;
  logic [7:0] cfg_dr = 8'h00;
  logic [3:0] cfg_cur_addr = 4'b0101;
  logic       flit_valid = 1'b0;
  logic [2:0] flit_id = 3'b000;
  logic [3:0] dst_addr = 4'b0000;
  logic       out_ready = 1'b0;
  logic       flit_ready;
  logic [4:0] port_req;
  logic       route_valid, derouted, route_err;

  lbdr_dr_route_unit #(.XW(XW), .YW(YW), .HDR_ID(HDR), .TAIL_ID(TAL)) dut (
    .clk(clk), .rst(rst), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_dr(cfg_dr),
    .cfg_cur_addr(cfg_cur_addr), .flit_valid(flit_valid), .flit_id(flit_id),
    .dst_addr(dst_addr), .out_ready(out_ready), .flit_ready(flit_ready),
    .port_req(port_req), .route_valid(route_valid), .derouted(derouted),
    .route_err(route_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbq[$];

  // model state: 0 idle, 1 hold, 2 drop
  int         m_st = 0;
  logic [7:0] m_rxy, m_dr;
  logic [3:0] m_cx, m_cur;
  logic [4:0] e_port = '0;
  logic       e_rv = 0, e_der = 0, e_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_route(input logic [3:0] dst, output logic ok, output logic der,
                           output logic [4:0] port);
    int xc, yc, xd, yd, d, code;
    logic n, s, e, w;
    logic [3:0] m, dirs;
    xc = int'(m_cur[1:0]); yc = int'(m_cur[3:2]);
    xd = int'(dst[1:0]);   yd = int'(dst[3:2]);
    n = yd < yc; s = yc < yd; e = xc < xd; w = xd < xc;
    dirs = {s, w, e, n};
    m[0] = n && ((!e && !w) || (e && m_rxy[0]) || (w && m_rxy[1])) && m_cx[0];
    m[1] = e && ((!n && !s) || (n && m_rxy[2]) || (s && m_rxy[3])) && m_cx[1];
    m[2] = w && ((!n && !s) || (n && m_rxy[4]) || (s && m_rxy[5])) && m_cx[2];
    m[3] = s && ((!e && !w) || (e && m_rxy[6]) || (w && m_rxy[7])) && m_cx[3];
    ok = 0; der = 0; port = '0;
    if (dirs == 4'b0) begin
      ok = 1; port = 5'b10000;
    end else if (m != 4'b0) begin
      ok = 1;
      for (int i = 3; i >= 0; i--) if (m[i]) port = 5'(1 << i);
    end else if ($countones(dirs) == 1) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (dirs[i]) d = i;
      code = int'((m_dr >> (2 * d)) & 8'h3);
      if (m_cx[code] && code != d) begin
        ok = 1; der = 1; port = 5'(1 << code);
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] id,
                      input logic [3:0] dst, input logic ordy, input string tag);
    logic exp_fr, ok, der;
    logic [4:0] p;
    @(negedge clk);
    rst = r; flit_valid = v; flit_id = id; dst_addr = dst; out_ready = ordy;
    #1;
    exp_fr = r ? 1'b0 : (m_st == 1 ? ordy : 1'b1);
    chk({tag, ".rdy"}, 32'(flit_ready), 32'(exp_fr));
    if (r) begin
      m_st = 0; e_port = '0; e_rv = 0; e_der = 0; e_err = 0;
      m_rxy = cfg_rxy; m_cx = cfg_cx; m_dr = cfg_dr; m_cur = cfg_cur_addr;
    end else begin
      e_err = 0;
      if (v && exp_fr) begin
        case (m_st)
          0, 1: begin
            if (id == HDR) begin
              ref_route(dst, ok, der, p);
              e_err = !ok || (m_st == 1);
              m_st = ok ? 1 : 2;
              e_port = ok ? p : 5'b0; e_rv = ok; e_der = ok && der;
            end else if (m_st == 0) begin
              e_err = 1;
            end else if (id == TAL) begin
              m_st = 0; e_port = '0; e_rv = 0; e_der = 0;
            end
          end
          default: if (id == TAL) m_st = 0;
        endcase
      end
    end
    sbq.push_back({e_port, e_rv, e_der, e_err});
    @(posedge clk);
    #1;
    chk({tag, ".out"}, 32'({port_req, route_valid, derouted, route_err}), 32'(sbq.pop_front()));
  endtask

  task automatic do_rst(input logic [3:0] cx, input logic [7:0] dr, input string tag);
    cfg_rxy = 8'h3C; cfg_cx = cx; cfg_dr = dr; cfg_cur_addr = 4'b0101;
    step(1, 0, PAY, 4'b0, 1, tag);
  endtask

  task automatic pkt(input logic [3:0] dst, input string tag);
    step(0, 1, HDR, dst, 1, {tag, ".h"});
    step(0, 1, PAY, 4'b0, 1, {tag, ".p"});
    step(0, 1, TAL, 4'b0, 1, {tag, ".t"});
    step(0, 0, PAY, 4'b0, 1, {tag, ".i"});
  endtask

  initial begin
    do_rst(4'hF, 8'h00, "rst0");
    do_rst(4'hF, 8'h00, "rst1");
    pkt(4'b0111, "t1_east");
    pkt(4'b0101, "t2_local");
    pkt(4'b0000, "diag_nw");
    pkt(4'b1111, "diag_se");
    pkt(4'b0011, "diag_ne");
    pkt(4'b1101, "south");

    do_rst(4'b1110, 8'h01, "t3_rst");
    pkt(4'b0001, "t3_derE");
    do_rst(4'b1110, 8'h00, "t3_rst2");
    pkt(4'b0001, "t3_fail");
    do_rst(4'b1100, 8'h01, "t3_rst3");
    pkt(4'b0001, "t3_cxfail");
    pkt(4'b0000, "t3_diagfail");

    do_rst(4'hF, 8'h00, "t4_rst");
    step(0, 1, HDR, 4'b0111, 1, "t4_h");
    for (int i = 0; i < 3; i++) step(0, 1, PAY, 4'b0, 0, "t4_stall");
    step(0, 1, PAY, 4'b0, 1, "t4_p");
    step(0, 1, TAL, 4'b0, 1, "t4_t");

    step(0, 1, HDR, 4'b0111, 1, "t5_h1");
    step(0, 1, PAY, 4'b0, 1, "t5_p");
    step(0, 1, HDR, 4'b0000, 1, "t5_h2");
    step(0, 1, TAL, 4'b0, 1, "t5_t");
    step(0, 1, PAY, 4'b0, 1, "t5_idlepay");
    step(0, 0, PAY, 4'b0, 1, "t5_i");

    step(0, 1, HDR, 4'b0111, 1, "t6_h");
    do_rst(4'b1110, 8'h01, "t6_rst");
    pkt(4'b0001, "t6_newcfg");

    do_rst(4'hF, 8'h00, "rnd_rst");
    for (int i = 0; i < 80; i++) begin
      logic [2:0] id;
      case ($urandom_range(0, 2))
        0: id = HDR;
        1: id = PAY;
        default: id = TAL;
      endcase
      step(0, 1'($urandom_range(0, 3) != 0), id, 4'($urandom),
           1'($urandom_range(0, 3) != 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
